// File: rtl/div_unit_if.sv
// Request/response bundle between the decode/regfile stage and the divider.
// The master side issues operations; the slave side is the divide unit.
interface div_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr_in;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr_out;

    modport master (
        output start, op, rs1_rdata, rs2_rdata, rd_addr_in, kill,
        input  busy, done, result, rd_addr_out
    );

    modport slave (
        input  start, op, rs1_rdata, rs2_rdata, rd_addr_in, kill,
        output busy, done, result, rd_addr_out
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring radix-2, one quotient bit
// per cycle on magnitudes, with sign fix-up in a final cycle.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   rem_reg, quo_reg, dvs_reg, result_reg;
    logic              is_rem_reg, neg_q_reg, neg_r_reg;
    logic [4:0]        rd_reg, rd_out_reg;

    // Operand decode, valid in IDLE while start is presented
    logic              is_signed, a_neg, b_neg, div_zero, ovf, accept;
    logic [XLEN-1:0]   a_abs, b_abs, special_res;

    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.rs1_rdata[XLEN-1];
    assign b_neg     = is_signed & bus.rs2_rdata[XLEN-1];
    assign a_abs     = a_neg ? -bus.rs1_rdata : bus.rs1_rdata;
    assign b_abs     = b_neg ? -bus.rs2_rdata : bus.rs2_rdata;
    assign div_zero  = (bus.rs2_rdata == '0);
    assign ovf       = is_signed && (bus.rs1_rdata == {1'b1, {(XLEN-1){1'b0}}})
                       && (bus.rs2_rdata == '1);
    assign accept    = bus.start && !bus.kill;

    // Overflow: quotient equals the dividend, remainder is zero
    assign special_res = div_zero ? (bus.op[1] ? bus.rs1_rdata : '1)
                                  : (bus.op[1] ? '0 : bus.rs1_rdata);

    // Partial remainder is always below the divisor, so the shifted value fits XLEN+1 bits
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;

    assign trial   = {rem_reg, quo_reg[XLEN-1]} - {1'b0, dvs_reg};
    assign q_fix   = neg_q_reg ? -quo_reg : quo_reg;
    assign r_fix   = neg_r_reg ? -rem_reg : rem_reg;
    assign fix_res = is_rem_reg ? r_fix : q_fix;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (div_zero || ovf) ? DONE : CALC;
            CALC: begin
                if (bus.kill)                            state_next = IDLE;
                else if (cnt_reg == CNT_W'(XLEN - 1))    state_next = FIX;
            end
            FIX:     state_next = bus.kill ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            result_reg <= '0;
            is_rem_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            rd_reg     <= '0;
            rd_out_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_rem_reg <= bus.op[1];
                        neg_q_reg  <= a_neg ^ b_neg;
                        neg_r_reg  <= a_neg;
                        rd_reg     <= bus.rd_addr_in;
                        rem_reg    <= '0;
                        quo_reg    <= a_abs;
                        dvs_reg    <= b_abs;
                        cnt_reg    <= '0;
                        if (div_zero || ovf) begin
                            result_reg <= special_res;
                            rd_out_reg <= bus.rd_addr_in;
                        end
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (!trial[XLEN]) begin
                        rem_reg <= trial[XLEN-1:0];
                        quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
                    end else begin
                        rem_reg <= {rem_reg[XLEN-2:0], quo_reg[XLEN-1]};
                        quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (!bus.kill) begin
                        result_reg <= fix_res;
                        rd_out_reg <= rd_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.result      = result_reg;
    assign bus.rd_addr_out = rd_out_reg;
endmodule

// File: tb/tb_div_unit.sv
// Directed plus random RV32M divide/remainder checks against an arithmetic
// reference model, including latency, start-while-busy, kill and reset abort.
module tb_div_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [XLEN-1:0] prev_res = '0;
    logic [4:0]      prev_rd  = '0;

    always #5 clk = ~clk;

    div_unit_if #(.XLEN(XLEN)) bus_if ();

    div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V semantics from plain arithmetic: truncating division, remainder takes dividend sign
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : a;
        if (!op[0])
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? a % b : a / b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // poke_kind: 0 none, 1 second start, 2 kill, 3 reset; poke driven at negedge j=poke_at
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input int poke_at, input int poke_kind);
        int first_done = -1;
        int ndone = 0;
        logic busy_after = 1'b1;
        logic busy_poke = 1'b1;
        logic [31:0] exp_res;
        int exp_lat;
        exp_res = ref_div(op, a, b);
        exp_lat = is_special(op, a, b) ? 0 : XLEN + 1;

        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = op; bus_if.rs1_rdata = a;
        bus_if.rs2_rdata = b; bus_if.rd_addr_in = rd;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        check({tag, " busy_after_start"}, 32'(bus_if.busy), 32'd1);

        for (int j = 0; j < 45; j++) begin
            if (j == poke_at + 1) begin
                bus_if.start = 1'b0; bus_if.kill = 1'b0; rst = 1'b0;
                busy_poke = bus_if.busy;
            end
            if (bus_if.done) begin
                ndone++;
                if (first_done < 0) first_done = j;
            end
            if (first_done >= 0 && j == first_done + 1) busy_after = bus_if.busy;
            if (j == poke_at) begin
                case (poke_kind)
                    1: begin
                        bus_if.start = 1'b1; bus_if.op = 2'b01; bus_if.rs1_rdata = 32'd9;
                        bus_if.rs2_rdata = 32'd3; bus_if.rd_addr_in = 5'd9;
                    end
                    2: bus_if.kill = 1'b1;
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
        end

        if (poke_kind <= 1) begin
            check({tag, " done_latency"}, 32'(first_done), 32'(exp_lat));
            check({tag, " done_count"}, 32'(ndone), 32'd1);
            check({tag, " result"}, bus_if.result, exp_res);
            check({tag, " rd_addr_out"}, 32'(bus_if.rd_addr_out), 32'(rd));
            check({tag, " busy_after_done"}, 32'(busy_after), 32'd0);
            prev_res = exp_res;
            prev_rd  = rd;
        end else begin
            check({tag, " busy_after_abort"}, 32'(busy_poke), 32'd0);
            check({tag, " no_done"}, 32'(ndone), 32'd0);
            if (poke_kind == 3) begin
                prev_res = '0;
                prev_rd  = '0;
            end
            check({tag, " result_held"}, bus_if.result, prev_res);
            check({tag, " rd_held"}, 32'(bus_if.rd_addr_out), 32'(prev_rd));
        end
        $display("txn %s op=%0d a=%h b=%h rd=%0d -> result=%h rd_out=%0d done_at=%0d",
                 tag, op, a, b, rd, bus_if.result, bus_if.rd_addr_out, first_done);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bus_if.start = 1'b0; bus_if.op = '0; bus_if.rs1_rdata = '0;
        bus_if.rs2_rdata = '0; bus_if.rd_addr_in = '0; bus_if.kill = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(bus_if.busy), 32'd0);
        check("reset done", 32'(bus_if.done), 32'd0);
        check("reset result", bus_if.result, 32'd0);
        check("reset rd", 32'(bus_if.rd_addr_out), 32'd0);

        run("divu_100_7",  2'b01, 32'd100, 32'd7, 5'd3, -10, 0);
        run("remu_100_7",  2'b11, 32'd100, 32'd7, 5'd3, -10, 0);
        run("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, -10, 0);
        run("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, -10, 0);
        run("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE, 5'd7, -10, 0);
        run("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 5'd8, -10, 0);
        run("divu_by0",    2'b01, 32'h1234, 32'd0, 5'd10, -10, 0);
        run("rem_by0",     2'b10, 32'h1234, 32'd0, 5'd11, -10, 0);
        run("div_0_0",     2'b00, 32'd0, 32'd0, 5'd12, -10, 0);
        run("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, -10, 0);
        run("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, -10, 0);
        run("start_busy",  2'b01, 32'd50, 32'd5, 5'd4, 4, 1);
        run("kill_mid",    2'b01, 32'd50, 32'd5, 5'd15, 9, 2);
        run("rst_mid",     2'b01, 32'd50, 32'd5, 5'd16, 9, 3);
        run("divu_max",    2'b01, 32'hFFFF_FFFF, 32'd1, 5'd17, -10, 0);

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom_range(0, 31)), -10, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
